rr_lock_arbiter: RTL and testbench

// - Round-robin arbiter with grant locking: shares one resource among N_REQ = 1<<IDX_W requesters.
// - Priority mask comes from accum_decoder, which produces a thermometer mask.
// - Owner holds the grant while its req stays high; optional MAX_HOLD timeout forces rotation.
// - Sits in front of shared core resources (memory port, shared ALU or bus).

---
 rtl/rr_lock_arbiter_pkg.sv | 28 ++
 rtl/rr_lock_arbiter_accum_decoder.sv | 23 ++
 rtl/rr_lock_arbiter.sv | 152 +++++++++++++++
 tb/tb_rr_lock_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/rr_lock_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_lock_arbiter_pkg
// Description : Shared types and helpers for the round-robin lock arbiter:
//               FSM state encoding and the hold-counter width function.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_lock_arbiter_pkg;

    // Arbiter FSM: either nobody owns the resource, or exactly one owner does
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Bits needed to count 0..max_hold (clog2(max_hold+1)), never below 1
    // so the counter still exists when the timeout is disabled.
    function automatic int hold_cnt_width(input int max_hold);
        int w;
        w = 1;
        while ((1 << w) < (max_hold + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_lock_arbiter_accum_decoder.sv
`default_nettype none
// ============================================================================
// Module      : accum_decoder
// Description : Thermometer decoder. mask[i] = 1 for every i below in_val;
//               'set' forces the whole mask to ones (used when in_val has
//               wrapped past the top index).
// Revision    : 1.0 - initial release
// ============================================================================
module accum_decoder #(
    parameter int N = 3
) (
    input  logic [N-1:0]        in_val,
    input  logic                set,
    output logic [(1<<N)-1:0]   mask
);

    for (genvar i = 0; i < (1 << N); i++) begin : g_therm
        localparam logic [N-1:0] c_idx = N'(i);
        assign mask[i] = set | (c_idx < in_val);
    end

endmodule
`default_nettype wire

// File: rtl/rr_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_lock_arbiter
// Description : Round-robin arbiter with grant locking. The owner keeps the
//               grant while its request stays high; an optional MAX_HOLD
//               timeout forces rotation when others are waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_lock_arbiter
    import rr_lock_arbiter_pkg::*;
#(
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [(1<<IDX_W)-1:0]   req,
    output logic [(1<<IDX_W)-1:0]   gnt,
    output logic [IDX_W-1:0]        gnt_idx,
    output logic                    gnt_valid,
    output logic                    gnt_new
);

    localparam int N_REQ  = 1 << IDX_W;
    localparam int HOLD_W = hold_cnt_width(MAX_HOLD);
    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic [IDX_W-1:0]  c_top_idx   = IDX_W'(N_REQ - 1);

    arb_state_t          r_state,    w_state_nxt;
    logic [IDX_W-1:0]    r_last_ptr, w_last_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt, w_hold_nxt;
    logic [N_REQ-1:0]    r_gnt,      w_gnt_nxt;
    logic [IDX_W-1:0]    r_gnt_idx,  w_idx_nxt;
    logic                r_gnt_new;
    logic                w_grant;

    logic [N_REQ-1:0]    w_mask_lo;
    logic [N_REQ-1:0]    w_req_hi;
    logic [N_REQ:0]      w_hi_below;
    logic [N_REQ:0]      w_all_below;
    logic [N_REQ-1:0]    w_hi_first;
    logic [N_REQ-1:0]    w_all_first;
    logic [N_REQ-1:0]    w_win_oh;
    logic [IDX_W-1:0]    w_win_idx;
    logic                w_timeout;

    // Requesters at or below the previous winner form the low-priority half.
    // When the previous winner is the top index, in_val wraps to 0 and 'set'
    // makes everything low priority so selection restarts from bit 0.
    accum_decoder #(.N(IDX_W)) u_mask (
        .in_val (r_last_ptr + IDX_W'(1)),
        .set    (r_last_ptr == c_top_idx),
        .mask   (w_mask_lo)
    );

    assign w_req_hi = req & ~w_mask_lo;

    // Lowest-set-bit pick for both the high-priority slice and the full vector
    assign w_hi_below[0]  = 1'b0;
    assign w_all_below[0] = 1'b0;
    for (genvar i = 0; i < N_REQ; i++) begin : g_prio_enc
        assign w_hi_first[i]    = w_req_hi[i] & ~w_hi_below[i];
        assign w_hi_below[i+1]  = w_hi_below[i] | w_req_hi[i];
        assign w_all_first[i]   = req[i] & ~w_all_below[i];
        assign w_all_below[i+1] = w_all_below[i] | req[i];
    end

    assign w_win_oh = (|w_req_hi) ? w_hi_first : w_all_first;

    // Encode the one-hot winner into an index
    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win_oh[i]) begin
                w_win_idx = w_win_idx | IDX_W'(i);
            end
        end
    end

    assign w_timeout = (MAX_HOLD != 0) && (r_hold_cnt == c_hold_last);

    // Next-state and next-output logic: decide whether a new grant is issued
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (|req) begin
                    w_grant = 1'b1;
                end
            end
            ARB_BUSY: begin
                // Release wins over a coincident timeout
                if (!req[r_gnt_idx]) begin
                    if (|req) begin
                        w_grant = 1'b1;
                    end else begin
                        w_state_nxt = ARB_IDLE;
                    end
                end else if (w_timeout && (|(req & ~r_gnt))) begin
                    w_grant = 1'b1;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
        if (w_grant) begin
            w_state_nxt = ARB_BUSY;
        end

        w_gnt_nxt  = r_gnt;
        w_idx_nxt  = r_gnt_idx;
        w_last_nxt = r_last_ptr;
        w_hold_nxt = r_hold_cnt;
        if (w_grant) begin
            w_gnt_nxt  = w_win_oh;
            w_idx_nxt  = w_win_idx;
            w_last_nxt = w_win_idx;
            w_hold_nxt = '0;
        end else if (w_state_nxt == ARB_IDLE) begin
            w_gnt_nxt  = '0;
            w_hold_nxt = '0;
        end else if (r_hold_cnt != c_hold_last) begin
            w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        end
    end

    // State and output registers; reset returns priority to requester 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_last_ptr <= c_top_idx;
            r_hold_cnt <= '0;
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_gnt_new  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_ptr <= w_last_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_idx  <= w_idx_nxt;
            r_gnt_new  <= w_grant;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = |r_gnt;
    assign gnt_new   = r_gnt_new;

endmodule
`default_nettype wire

// File: tb/tb_rr_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_lock_arbiter
// Description : Directed self-checking bench for rr_lock_arbiter
//               (IDX_W=3, MAX_HOLD=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_lock_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       gnt_new;

    int n_cmp;
    int n_err;

    rr_lock_arbiter #(.IDX_W(3), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .gnt_new   (gnt_new)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, and check the output invariants
    task automatic step();
        @(posedge clk);
        #1;
        chk("valid_eq_or_gnt", {31'd0, gnt_valid}, {31'd0, (gnt != 8'h00)});
        chk("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
    endtask

    // Check grant vector, valid and new-grant pulse together
    task automatic chk_g(input string tag, input logic [7:0] eg, input logic en);
        chk({tag, "_gnt"}, {24'd0, gnt}, {24'd0, eg});
        chk({tag, "_new"}, {31'd0, gnt_new}, {31'd0, en});
    endtask

    logic [7:0] exp_gnt;
    logic       exp_new;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        req   = 8'hFF;

        // Reset held two cycles with all requests up
        step();
        step();
        chk_g("rst", 8'h00, 1'b0);
        chk("rst_valid", {31'd0, gnt_valid}, 32'd0);
        chk("rst_idx", {29'd0, gnt_idx}, 32'd0);

        // Release reset: requester 0 has top priority
        rst = 1'b0;
        step();
        chk_g("first", 8'h01, 1'b1);
        chk("first_idx", {29'd0, gnt_idx}, 32'd0);
        req = 8'h00;
        step();
        chk_g("first_rel", 8'h00, 1'b0);

        // Single requester
        req = 8'h04;
        step();
        chk_g("single", 8'h04, 1'b1);
        chk("single_idx", {29'd0, gnt_idx}, 32'd2);
        step();
        chk_g("single_hold", 8'h04, 1'b0);
        req = 8'h00;
        step();
        chk_g("single_rel", 8'h00, 1'b0);
        chk("single_rel_valid", {31'd0, gnt_valid}, 32'd0);

        // Rotation 0 -> 2 -> 0 without an idle bubble (last_ptr=2 here)
        req = 8'h05;
        step();
        chk_g("rot0", 8'h01, 1'b1);
        req = 8'h04;
        step();
        chk_g("rot2", 8'h04, 1'b1);
        chk("rot2_idx", {29'd0, gnt_idx}, 32'd2);
        req = 8'h01;
        step();
        chk_g("rot0b", 8'h01, 1'b1);
        req = 8'h00;
        step();
        chk_g("rot_idle", 8'h00, 1'b0);

        // Wrap: owner 7 releases while 0 waits
        req = 8'h80;
        step();
        chk_g("wrap7", 8'h80, 1'b1);
        chk("wrap7_idx", {29'd0, gnt_idx}, 32'd7);
        step();
        chk_g("wrap7_hold", 8'h80, 1'b0);
        req = 8'h81;
        step();
        chk_g("wrap7_lock", 8'h80, 1'b0);
        req = 8'h01;
        step();
        chk_g("wrap0", 8'h01, 1'b1);
        req = 8'h80;
        step();
        chk_g("wrap7b", 8'h80, 1'b1);
        req = 8'h00;
        step();
        chk_g("wrap_idle", 8'h00, 1'b0);

        // Timeout rotation with two constant requesters (last_ptr=7)
        req = 8'h03;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp_gnt = (k <= 4) ? 8'h01 : ((k <= 8) ? 8'h02 : 8'h01);
            exp_new = (k == 1) || (k == 5) || (k == 9);
            chk_g($sformatf("tmo_c%0d", k), exp_gnt, exp_new);
        end

        // Sole requester is never preempted
        req = 8'h01;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk_g($sformatf("solo_c%0d", k), 8'h01, 1'b0);
        end
        req = 8'h00;
        step();
        chk_g("solo_rel", 8'h00, 1'b0);

        // Reset mid-grant drops the grant on the reset edge
        req = 8'h08;
        step();
        chk_g("mid_own3", 8'h08, 1'b1);
        chk("mid_own3_idx", {29'd0, gnt_idx}, 32'd3);
        rst = 1'b1;
        step();
        chk_g("mid_rst", 8'h00, 1'b0);
        chk("mid_rst_idx", {29'd0, gnt_idx}, 32'd0);
        rst = 1'b0;
        step();
        chk_g("mid_regrant", 8'h08, 1'b1);
        chk("mid_regrant_idx", {29'd0, gnt_idx}, 32'd3);

        // After reset last_ptr is 7 again: with 0 and 3 competing from idle, 0 wins
        req = 8'h00;
        step();
        chk_g("post_idle", 8'h00, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 8'h09;
        step();
        chk_g("post_rst_pick0", 8'h01, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
